// File: rtl/axil_pkg.sv
// Shared definitions for the AXI4-Lite to microprocessor-bus bridge:
// response codes, bridge FSM states and the default timeout read data.
package axil_pkg;

  localparam logic [1:0]  RESP_OKAY    = 2'b00;
  localparam logic [1:0]  RESP_SLVERR  = 2'b10;
  localparam logic [31:0] TMO_DATA_DEF = 32'hDEAD_BEEF;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WR_ACT = 3'd1,
    ST_RD_ACT = 3'd2,
    ST_WR_RSP = 3'd3,
    ST_RD_RSP = 3'd4
  } state_e;

  // Round-robin pointer: which side wins when write and read are both pending.
  typedef enum logic {
    PTR_WR = 1'b0,
    PTR_RD = 1'b1
  } rr_ptr_e;

endpackage

// File: rtl/up_tmo.sv
// Watchdog for up-side masters: counts enabled cycles since the last clear and
// pulses expire on the TMO_CYC-th enabled cycle.
module up_tmo #(
  parameter int unsigned TMO_CYC = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int CNT_W = 16;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear)       cnt_d = '0;
    else if (enable) cnt_d = cnt_q + 1'b1;
  end

  // NOTE: state flops use non-blocking assignments so every flop samples the
  // pre-edge values of its neighbours, exactly like the hardware.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  // The owner leaves its active state on expiry, so this is a single-cycle pulse.
  assign expire = enable && !clear && (cnt_q == CNT_W'(TMO_CYC - 1));

endmodule

// File: rtl/axil2up_bridge.sv
// AXI4-Lite slave that converts AW/W and AR handshakes into level write/read
// requests for rwsgen, holding the up-side bus stable until uprdy or timeout.
module axil2up_bridge
  import axil_pkg::*;
#(
  parameter int unsigned        ADDR_W   = 16,
  parameter int unsigned        DATA_W   = 32,
  parameter int unsigned        TMO_CYC  = 255,
  parameter logic [DATA_W-1:0]  TMO_DATA = DATA_W'(TMO_DATA_DEF)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                awvalid,
  output logic                awready,
  input  logic [ADDR_W-1:0]   awaddr,
  input  logic                wvalid,
  output logic                wready,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  output logic                bvalid,
  input  logic                bready,
  output logic [1:0]          bresp,
  input  logic                arvalid,
  output logic                arready,
  input  logic [ADDR_W-1:0]   araddr,
  output logic                rvalid,
  input  logic                rready,
  output logic [DATA_W-1:0]   rdata,
  output logic [1:0]          rresp,
  output logic                write,
  output logic                read,
  output logic [ADDR_W-1:0]   upa,
  output logic [DATA_W-1:0]   updo,
  output logic [DATA_W/8-1:0] upbe,
  input  logic [DATA_W-1:0]   updi,
  input  logic                uprdy
);

  state_e                state_q, state_d;
  rr_ptr_e               rr_q, rr_d;
  logic                  write_q, write_d, read_q, read_d;
  logic                  bvalid_q, bvalid_d, rvalid_q, rvalid_d;
  logic [1:0]            bresp_q, bresp_d, rresp_q, rresp_d;
  logic [DATA_W-1:0]     rdata_q, rdata_d, updo_q, updo_d;
  logic [ADDR_W-1:0]     upa_q, upa_d;
  logic [DATA_W/8-1:0]   upbe_q, upbe_d;

  logic wr_pend, rd_pend, wr_grant, rd_grant, is_idle, is_act, tmo_expire;

  assign wr_pend  = awvalid && wvalid;
  assign rd_pend  = arvalid;
  assign wr_grant = wr_pend && (!rd_pend || (rr_q == PTR_WR));
  assign rd_grant = rd_pend && (!wr_pend || (rr_q == PTR_RD));
  assign is_idle  = (state_q == ST_IDLE);
  assign is_act   = (state_q == ST_WR_ACT) || (state_q == ST_RD_ACT);

  // Gated by rst_n so every output reads 0 while reset is held.
  assign awready = rst_n && is_idle && wr_grant;
  assign wready  = awready;
  assign arready = rst_n && is_idle && rd_grant;

  up_tmo #(.TMO_CYC(TMO_CYC)) u_tmo (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (!is_act),
    .enable (is_act),
    .expire (tmo_expire)
  );

  always_comb begin
    // NOTE: every next-state value defaults to its current value first, so no
    // path through the case leaves a signal unassigned and no latch is inferred.
    state_d  = state_q;
    rr_d     = rr_q;
    write_d  = write_q;
    read_d   = read_q;
    bvalid_d = bvalid_q;
    rvalid_d = rvalid_q;
    bresp_d  = bresp_q;
    rresp_d  = rresp_q;
    rdata_d  = rdata_q;
    upa_d    = upa_q;
    updo_d   = updo_q;
    upbe_d   = upbe_q;
    unique case (state_q)
      ST_IDLE: begin
        if (wr_grant) begin
          state_d = ST_WR_ACT;
          write_d = 1'b1;
          upa_d   = awaddr;
          updo_d  = wdata;
          upbe_d  = wstrb;
          rr_d    = (rr_q == PTR_WR) ? PTR_RD : PTR_WR;
        end else if (rd_grant) begin
          state_d = ST_RD_ACT;
          read_d  = 1'b1;
          upa_d   = araddr;
          rr_d    = (rr_q == PTR_WR) ? PTR_RD : PTR_WR;
        end
      end
      ST_WR_ACT: begin
        // A late uprdy coinciding with expiry still counts as a clean ack.
        if (uprdy || tmo_expire) begin
          state_d  = ST_WR_RSP;
          write_d  = 1'b0;
          bvalid_d = 1'b1;
          bresp_d  = uprdy ? RESP_OKAY : RESP_SLVERR;
        end
      end
      ST_RD_ACT: begin
        if (uprdy || tmo_expire) begin
          state_d  = ST_RD_RSP;
          read_d   = 1'b0;
          rvalid_d = 1'b1;
          rresp_d  = uprdy ? RESP_OKAY : RESP_SLVERR;
          rdata_d  = uprdy ? updi : TMO_DATA;
        end
      end
      ST_WR_RSP: begin
        if (bready) begin
          state_d  = ST_IDLE;
          bvalid_d = 1'b0;
        end
      end
      ST_RD_RSP: begin
        if (rready) begin
          state_d  = ST_IDLE;
          rvalid_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      rr_q     <= PTR_WR;
      write_q  <= 1'b0;
      read_q   <= 1'b0;
      bvalid_q <= 1'b0;
      rvalid_q <= 1'b0;
      bresp_q  <= RESP_OKAY;
      rresp_q  <= RESP_OKAY;
      rdata_q  <= '0;
      upa_q    <= '0;
      updo_q   <= '0;
      upbe_q   <= '0;
    end else begin
      state_q  <= state_d;
      rr_q     <= rr_d;
      write_q  <= write_d;
      read_q   <= read_d;
      bvalid_q <= bvalid_d;
      rvalid_q <= rvalid_d;
      bresp_q  <= bresp_d;
      rresp_q  <= rresp_d;
      rdata_q  <= rdata_d;
      upa_q    <= upa_d;
      updo_q   <= updo_d;
      upbe_q   <= upbe_d;
    end
  end

  assign write  = write_q;
  assign read   = read_q;
  assign bvalid = bvalid_q;
  assign rvalid = rvalid_q;
  assign bresp  = bresp_q;
  assign rresp  = rresp_q;
  assign rdata  = rdata_q;
  assign upa    = upa_q;
  assign updo   = updo_q;
  assign upbe   = upbe_q;

endmodule

// File: tb/tb_axil2up_bridge.sv
// Bench for axil2up_bridge: transaction-level reference model checked every
// cycle, an rwsgen-like uprdy responder, and directed scenarios with literals.
module tb_axil2up_bridge;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 32;
  localparam int TMO    = 8;

  logic clk = 1'b0, rst_n = 1'b0;
  logic awvalid = 0, wvalid = 0, bready = 0, arvalid = 0, rready = 0, uprdy = 0;
  logic [ADDR_W-1:0] awaddr = '0, araddr = '0;
  logic [DATA_W-1:0] wdata = '0, updi = '0;
  logic [3:0] wstrb = '0;
  logic awready, wready, bvalid, arready, rvalid, write, read;
  logic [1:0] bresp, rresp;
  logic [DATA_W-1:0] rdata, updo;
  logic [ADDR_W-1:0] upa;
  logic [3:0] upbe;

  int n_vec = 0, n_err = 0;

  axil2up_bridge #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TMO_CYC(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
    .bvalid(bvalid), .bready(bready), .bresp(bresp),
    .arvalid(arvalid), .arready(arready), .araddr(araddr),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
    .write(write), .read(read), .upa(upa), .updo(updo), .upbe(upbe),
    .updi(updi), .uprdy(uprdy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (transaction level) ----------------
  // phase 0: no op, 1: request outstanding on up side, 2: response owed on AXI
  int                m_phase, m_age;
  bit                m_is_wr, m_ptr_rd;
  logic [ADDR_W-1:0] m_upa;
  logic [DATA_W-1:0] m_updo, m_rdata;
  logic [3:0]        m_upbe;
  logic [1:0]        m_resp;

  function automatic bit model_take_write();
    return awvalid && wvalid && (!arvalid || !m_ptr_rd);
  endfunction

  function automatic bit model_take_read();
    return arvalid && !(awvalid && wvalid && (!arvalid || !m_ptr_rd));
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase <= 0; m_age <= 0; m_is_wr <= 0; m_ptr_rd <= 0;
      m_upa <= '0; m_updo <= '0; m_upbe <= '0; m_rdata <= '0; m_resp <= 2'b00;
    end else if (m_phase == 0) begin
      if (model_take_write() || model_take_read()) begin
        m_phase  <= 1;
        m_age    <= 1;
        m_ptr_rd <= !m_ptr_rd;
        m_is_wr  <= model_take_write();
        if (model_take_write()) begin
          m_upa <= awaddr; m_updo <= wdata; m_upbe <= wstrb;
        end else begin
          m_upa <= araddr;
        end
      end
    end else if (m_phase == 1) begin
      if (uprdy === 1'b1) begin
        m_phase <= 2; m_resp <= 2'b00;
        if (!m_is_wr) m_rdata <= updi;
      end else if (m_age == TMO) begin
        m_phase <= 2; m_resp <= 2'b10;
        if (!m_is_wr) m_rdata <= 32'hDEAD_BEEF;
      end else begin
        m_age <= m_age + 1;
      end
    end else if (m_is_wr ? bready : rready) begin
      m_phase <= 0;
    end
  end

  // ---------------- per-cycle compare + strobe log ----------------
  logic prev_w = 0, prev_r = 0;
  int   op_cnt = 0;
  logic [7:0] op_bits = '0;

  always @(negedge clk) begin
    #2;
    check("write",   write,   (m_phase == 1) &&  m_is_wr);
    check("read",    read,    (m_phase == 1) && !m_is_wr);
    check("bvalid",  bvalid,  (m_phase == 2) &&  m_is_wr);
    check("rvalid",  rvalid,  (m_phase == 2) && !m_is_wr);
    check("awready", awready, rst_n && (m_phase == 0) && model_take_write());
    check("wready",  wready,  rst_n && (m_phase == 0) && model_take_write());
    check("arready", arready, rst_n && (m_phase == 0) && model_take_read());
    check("upa",  upa,  m_upa);
    check("updo", updo, m_updo);
    check("upbe", upbe, m_upbe);
    if (bvalid) check("bresp", bresp, m_resp);
    if (rvalid) begin
      check("rresp", rresp, m_resp);
      check("rdata", rdata, m_rdata);
    end
    if ((write && !prev_w) || (read && !prev_r)) begin
      check("idle_gap_before_op", {prev_w, prev_r}, 2'b00);
      op_cnt++;
      op_bits = {op_bits[6:0], write};
    end
    prev_w = write;
    prev_r = read;
  end

  // ---------------- rwsgen-like responder ----------------
  int   rdy_dly   = -1;
  logic force_rdy = 0;
  always @(negedge clk) begin : responder
    int act_cyc;
    if (write || read) begin
      uprdy   = ((rdy_dly >= 0) && (act_cyc == rdy_dly)) || force_rdy;
      act_cyc = act_cyc + 1;
    end else begin
      act_cyc = 0;
      uprdy   = force_rdy;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic do_write(input logic [15:0] a, input logic [31:0] d, input logic [3:0] s);
    bit done = 0;
    @(negedge clk);
    awvalid = 1; wvalid = 1; awaddr = a; wdata = d; wstrb = s;
    for (int i = 0; i < 20 && !done; i++) begin
      #1;
      if (awready && wready) done = 1;
      @(negedge clk);
    end
    awvalid = 0; wvalid = 0;
    if (!done) check("aw_w_handshake_timeout", 0, 1);
  endtask

  task automatic do_read(input logic [15:0] a);
    bit done = 0;
    @(negedge clk);
    arvalid = 1; araddr = a;
    for (int i = 0; i < 20 && !done; i++) begin
      #1;
      if (arready) done = 1;
      @(negedge clk);
    end
    arvalid = 0;
    if (!done) check("ar_handshake_timeout", 0, 1);
  endtask

  // Entered at a negedge just after the accepting edge; returns at negedge+1
  // with the response valid, reporting how many cycles the request was high.
  task automatic wait_resp(input bit is_wr, input logic [15:0] ea, input logic [31:0] ed,
                           output int act_cycles);
    bit done = 0;
    act_cycles = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      #1;
      if (write || read) begin
        act_cycles++;
        check("upa_stable", upa, ea);
        if (is_wr) check("updo_stable", updo, ed);
      end
      if (is_wr ? bvalid : rvalid) done = 1;
      else @(negedge clk);
    end
    if (!done) check("response_timeout", 0, 1);
  endtask

  task automatic ack_b();
    @(negedge clk); bready = 1;
    @(negedge clk); bready = 0;
    #1 check("bvalid_after_bready", bvalid, 0);
  endtask

  task automatic ack_r();
    @(negedge clk); rready = 1;
    @(negedge clk); rready = 0;
    #1 check("rvalid_after_rready", rvalid, 0);
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    int n;
    repeat (3) @(negedge clk);
    #1;
    check("reset_write",   write,   0);
    check("reset_bvalid",  bvalid,  0);
    check("reset_rvalid",  rvalid,  0);
    check("reset_upa",     upa,     0);
    @(negedge clk); rst_n = 1;

    // 1: single write, uprdy 3 cycles after write rises
    rdy_dly = 3;
    do_write(16'h0010, 32'h1234_5678, 4'hF);
    wait_resp(1, 16'h0010, 32'h1234_5678, n);
    check("t1_write_cycles", n, 4);
    check("t1_bresp", bresp, 2'b00);
    check("t1_upbe", upbe, 4'hF);
    ack_b();

    // 2: single read, uprdy on the 5th active cycle
    rdy_dly = 4; updi = 32'hCAFE_F00D;
    do_read(16'h0020);
    wait_resp(0, 16'h0020, 32'h0, n);
    check("t2_read_cycles", n, 5);
    check("t2_rdata", rdata, 32'hCAFE_F00D);
    check("t2_rresp", rresp, 2'b00);
    ack_r();

    // 3: read timeout, late uprdy ignored
    rdy_dly = -1; updi = 32'h1111_2222;
    do_read(16'h0030);
    wait_resp(0, 16'h0030, 32'h0, n);
    check("t3_read_cycles", n, TMO);
    check("t3_rresp", rresp, 2'b10);
    check("t3_rdata", rdata, 32'hDEAD_BEEF);
    @(negedge clk); #1 force_rdy = 1;
    @(negedge clk); #1 force_rdy = 0;
    repeat (2) @(negedge clk);
    #1;
    check("t3_rvalid_held", rvalid, 1);
    check("t3_rdata_held", rdata, 32'hDEAD_BEEF);
    check("t3_read_low", read, 0);
    ack_r();

    // 5: AW three cycles ahead of W
    rdy_dly = 0;
    @(negedge clk);
    awvalid = 1; awaddr = 16'h0050; wdata = 32'h5555_AAAA; wstrb = 4'h5;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("t5_awready_wait", awready, 0);
      check("t5_wready_wait", wready, 0);
      @(negedge clk);
    end
    wvalid = 1;
    #1;
    check("t5_awready", awready, 1);
    check("t5_wready", wready, 1);
    @(negedge clk); awvalid = 0; wvalid = 0;
    wait_resp(1, 16'h0050, 32'h5555_AAAA, n);
    check("t5_write_cycles", n, 1);
    ack_b();

    // 4: write and read both pending continuously for four ops
    rdy_dly = 1; bready = 1; rready = 1; updi = 32'h0BAD_F00D;
    op_cnt = 0; op_bits = '0;
    @(negedge clk);
    awvalid = 1; wvalid = 1; awaddr = 16'h0040; wdata = 32'hA5A5_A5A5; wstrb = 4'h3;
    arvalid = 1; araddr = 16'h0044;
    for (int i = 0; i < 100 && op_cnt < 4; i++) begin
      @(negedge clk); #3;
    end
    awvalid = 0; wvalid = 0; arvalid = 0;
    repeat (6) @(negedge clk);
    check("t4_op_count", op_cnt, 4);
    check("t4_grant_order_WRWR", op_bits[3:0], 4'b1010);
    bready = 0; rready = 0;

    // 6: asynchronous reset in the middle of a write
    rdy_dly = -1;
    do_write(16'h0060, 32'h6666_7777, 4'hF);
    @(negedge clk); #3 rst_n = 0;
    #1;
    check("t6_write_in_reset", write, 0);
    check("t6_bvalid_in_reset", bvalid, 0);
    check("t6_awready_in_reset", awready, 0);
    check("t6_upa_in_reset", upa, 0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    n = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk); #1;
      if (bvalid) n++;
    end
    check("t6_no_bvalid_after_abort", n, 0);
    rdy_dly = 2;
    do_write(16'h0070, 32'h0F0F_0F0F, 4'hC);
    wait_resp(1, 16'h0070, 32'h0F0F_0F0F, n);
    check("t6_next_write_cycles", n, 3);
    check("t6_next_bresp", bresp, 2'b00);
    ack_b();

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    n_err++;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
